// File: rtl/muldiv_unit_pkg.sv
// Multiply/divide unit shared types: MDU op codes and FSM states.
// Imported by the MDU interface and the MDU top.
package muldiv_unit_pkg;

  localparam int MDU_WIDTH = 32;

  typedef logic [2:0] mdu_op_t;

  localparam mdu_op_t MDU_NOP   = 3'd0;
  localparam mdu_op_t MDU_MULT  = 3'd1;
  localparam mdu_op_t MDU_MULTU = 3'd2;
  localparam mdu_op_t MDU_DIV   = 3'd3;
  localparam mdu_op_t MDU_DIVU  = 3'd4;
  localparam mdu_op_t MDU_MTHI  = 3'd5;
  localparam mdu_op_t MDU_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_FIX  = 2'd2
  } mdu_state_e;

  function automatic logic mdu_signed(
    input mdu_op_t op
  );
    return (op == MDU_MULT) ||
           (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// MDU issue/result bundle: start/op/A/B in, busy/done/HI/LO out.
// master = control/execute side, slave = muldiv_unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  import muldiv_unit_pkg::*;

  logic             start;
  mdu_op_t          op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output start, op, A, B,
    input  busy, done, HI, LO
  );

  modport slave (
    input  start, op, A, B,
    output busy, done, HI, LO
  );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO (plus MTHI/MTLO).
// Ports: clk, rst (sync, active high), bus (muldiv_unit_if.slave).
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam int DW = 2 * WIDTH;

  mdu_state_e state, state_n;

  logic [CW-1:0]    cnt;
  logic [DW-1:0]    acc;
  logic [DW-1:0]    acc_n;
  logic [WIDTH-1:0] opd;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             dz;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             done_q;

  logic             op_mul;
  logic             op_div;
  logic             op_md;
  logic             op_mthi;
  logic             op_mtlo;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic             ge;
  logic [WIDTH-1:0] rem_sub;
  logic [DW-1:0]    prod;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  always_comb begin
    op_mul  = 1'b0;
    op_div  = 1'b0;
    op_mthi = 1'b0;
    op_mtlo = 1'b0;
    unique case (bus.op)
      MDU_MULT,
      MDU_MULTU: op_mul  = 1'b1;
      MDU_DIV,
      MDU_DIVU:  op_div  = 1'b1;
      MDU_MTHI:  op_mthi = 1'b1;
      MDU_MTLO:  op_mtlo = 1'b1;
      default:   ;
    endcase
    op_md = op_mul | op_div;
    a_neg = mdu_signed(bus.op) & bus.A[WIDTH-1];
    b_neg = mdu_signed(bus.op) & bus.B[WIDTH-1];
    a_mag = a_neg ? -bus.A : bus.A;
    b_mag = b_neg ? -bus.B : bus.B;
  end

  // acc: multiply = {product hi, multiplier}, shifted right;
  //      divide   = {remainder, dividend/quotient}, shifted left.
  always_comb begin
    sum     = {1'b0, acc[DW-1:WIDTH]}
            + {1'b0, opd & {WIDTH{acc[0]}}};
    shl     = acc[DW-1:WIDTH-1];
    ge      = shl >= {1'b0, opd};
    rem_sub = shl[WIDTH-1:0] - opd;
    if (is_div) begin
      if (ge)
        acc_n = {rem_sub, acc[WIDTH-2:0], 1'b1};
      else
        acc_n = {acc[DW-2:0], 1'b0};
    end else begin
      acc_n = {sum, acc[WIDTH-1:1]};
    end
    prod  = neg_q ? -acc : acc;
    q_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r_fix = neg_r ? -acc[DW-1:WIDTH] : acc[DW-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= MDU_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      MDU_IDLE:
        if (bus.start && op_md)
          state_n = MDU_CALC;
      MDU_CALC:
        if (cnt == CW'(WIDTH - 1))
          state_n = MDU_FIX;
      MDU_FIX:
        state_n = MDU_IDLE;
      default:
        state_n = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      opd    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        MDU_IDLE: begin
          if (bus.start) begin
            unique case (1'b1)
              op_md: begin
                cnt    <= '0;
                is_div <= op_div;
                neg_q  <= a_neg ^ b_neg;
                neg_r  <= a_neg;
                dz     <= op_div && (bus.B == '0);
                acc    <= {{WIDTH{1'b0}},
                           op_div ? a_mag : b_mag};
                opd    <= op_div ? b_mag : a_mag;
              end
              op_mthi: begin
                hi     <= bus.A;
                done_q <= 1'b1;
              end
              op_mtlo: begin
                lo     <= bus.A;
                done_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        MDU_CALC: begin
          acc <= acc_n;
          cnt <= cnt + CW'(1);
        end
        MDU_FIX: begin
          done_q <= 1'b1;
          if (is_div) begin
            // B=0 leaves |A| in the remainder, so HI=A falls out.
            hi <= r_fix;
            lo <= dz ? '1 : q_fix;
          end else begin
            hi <= prod[DW-1:WIDTH];
            lo <= prod[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != MDU_IDLE);
  assign bus.done = done_q;
  assign bus.HI   = hi;
  assign bus.LO   = lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit.
// Directed vectors plus random ops checked against an arithmetic model.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] ref_hi;
  logic [31:0] ref_lo;

  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic void model(
    input  mdu_op_t     o,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] h,
    output logic [31:0] l
  );
    int          sa;
    int          sb;
    longint      pa;
    longint      pb;
    logic [63:0] p;
    sa = a;
    sb = b;
    h  = '0;
    l  = '0;
    case (o)
      MDU_MULT: begin
        pa = longint'(sa);
        pb = longint'(sb);
        p  = pa * pb;
        h  = p[63:32];
        l  = p[31:0];
      end
      MDU_MULTU: begin
        p = {32'd0, a} * {32'd0, b};
        h = p[63:32];
        l = p[31:0];
      end
      MDU_DIV: begin
        if (b == 0) begin
          h = a;
          l = '1;
        end else if (a == 32'h8000_0000 && b == '1) begin
          h = '0;
          l = a;
        end else begin
          l = sa / sb;
          h = sa % sb;
        end
      end
      MDU_DIVU: begin
        if (b == 0) begin
          h = a;
          l = '1;
        end else begin
          l = a / b;
          h = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  // Starts at #1 after an edge; returns in the done cycle.
  task automatic run_op(
    input mdu_op_t     o,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] eh,
    input logic [31:0] el,
    input int          pulse_at,
    input string       nm
  );
    int n;
    int bh;
    bus.start = 1'b1;
    bus.op    = o;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op    = MDU_NOP;
    bus.A     = $urandom;
    bus.B     = $urandom;
    n  = 0;
    bh = 0;
    while (bus.done !== 1'b1 && n < 40) begin
      if (bus.busy === 1'b1) bh++;
      if (n == pulse_at) begin
        bus.start = 1'b1;
        bus.op    = MDU_MULT;
        bus.A     = $urandom;
        bus.B     = $urandom;
      end
      if (n == pulse_at + 1) begin
        bus.start = 1'b0;
        bus.op    = MDU_NOP;
      end
      @(posedge clk); #1;
      n++;
    end
    bus.start = 1'b0;
    checks++;
    if (n != 33) begin
      errors++;
      $display("FAIL %s_latency got=%0d want=33 edges", nm, n);
    end
    checks++;
    if (bh != 33) begin
      errors++;
      $display("FAIL %s_busy_cycles got=%0d want=33", nm, bh);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_in_done got=%b want=0", nm, bus.busy);
    end
    checks++;
    if (bus.HI !== eh) begin
      errors++;
      $display("FAIL %s_hi got=%h want=%h", nm, bus.HI, eh);
    end
    checks++;
    if (bus.LO !== el) begin
      errors++;
      $display("FAIL %s_lo got=%h want=%h", nm, bus.LO, el);
    end
    ref_hi = eh;
    ref_lo = el;
  endtask

  task automatic gap_check(input string nm);
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL %s_done_pulse got=%b want=0", nm, bus.done);
    end
    checks++;
    if (bus.HI !== ref_hi || bus.LO !== ref_lo) begin
      errors++;
      $display("FAIL %s_hold got=%h_%h want=%h_%h",
               nm, bus.HI, bus.LO, ref_hi, ref_lo);
    end
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = MDU_NOP;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got=%b want=0", bus.busy);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got=%b want=0", bus.done);
    end
    checks++;
    if (bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
      errors++;
      $display("FAIL reset_hilo got=%h_%h want=0_0", bus.HI, bus.LO);
    end
    rst    = 1'b0;
    ref_hi = '0;
    ref_lo = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_mt;
    logic [31:0] v [2];
    mdu_op_t     o [2];
    v[0] = 32'h1234_5678;
    v[1] = 32'hCAFE_BABE;
    o[0] = MDU_MTHI;
    o[1] = MDU_MTLO;
    for (int i = 0; i < 2; i++) begin
      bus.start = 1'b1;
      bus.op    = o[i];
      bus.A     = v[i];
      bus.B     = $urandom;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.op    = MDU_NOP;
      if (i == 0) ref_hi = v[0];
      else        ref_lo = v[1];
      checks++;
      if (bus.HI !== ref_hi || bus.LO !== ref_lo) begin
        errors++;
        $display("FAIL mt%0d_hilo got=%h_%h want=%h_%h",
                 i, bus.HI, bus.LO, ref_hi, ref_lo);
      end
      checks++;
      if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL mt%0d_handshake got=d%b_b%b want=d1_b0",
                 i, bus.done, bus.busy);
      end
      gap_check("mt");
      checks++;
      if (bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL mt%0d_busy got=%b want=0", i, bus.busy);
      end
    end
  endtask

  task automatic test_ignored_op;
    mdu_op_t o [2];
    o[0] = MDU_NOP;
    o[1] = 3'd7;
    for (int i = 0; i < 2; i++) begin
      bus.start = 1'b1;
      bus.op    = o[i];
      bus.A     = $urandom;
      bus.B     = $urandom;
      @(posedge clk); #1;
      bus.start = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL badop%0d_handshake got=b%b_d%b want=b0_d0",
                 i, bus.busy, bus.done);
      end
      gap_check("badop");
    end
  endtask

  task automatic test_vectors;
    run_op(MDU_MULT, 32'hFFFF_FFFD, 32'd5,
           32'hFFFF_FFFF, 32'hFFFF_FFF1, -5, "mult");
    gap_check("mult");
    run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'h0000_0001, -5, "multu");
    gap_check("multu");
    run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, -5, "div");
    gap_check("div");
    run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h0000_0000, 32'h8000_0000, -5, "divovf");
    gap_check("divovf");
    run_op(MDU_DIVU, 32'd100, 32'd0,
           32'h0000_0064, 32'hFFFF_FFFF, -5, "divz");
    gap_check("divz");
    run_op(MDU_DIV, 32'hFFFF_FF38, 32'd0,
           32'hFFFF_FF38, 32'hFFFF_FFFF, -5, "sdivz");
    gap_check("sdivz");
  endtask

  task automatic test_start_while_busy;
    run_op(MDU_DIVU, 32'd10, 32'd3,
           32'd1, 32'd3, 4, "busy_start");
    gap_check("busy_start");
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_restart got=%b want=0", bus.busy);
    end
  endtask

  task automatic rand_op(
    output mdu_op_t     o,
    output logic [31:0] a,
    output logic [31:0] b
  );
    int r;
    o = mdu_op_t'($urandom_range(1, 4));
    a = $urandom;
    b = $urandom;
    r = $urandom_range(0, 7);
    if (r == 0) b = '0;
    if (r == 1) b = $urandom_range(1, 15);
    if (r == 2) b = '1;
    if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
  endtask

  task automatic test_random;
    mdu_op_t     o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
    for (int i = 0; i < 24; i++) begin
      rand_op(o, a, b);
      model(o, a, b, eh, el);
      run_op(o, a, b, eh, el, -5, "rand");
      gap_check("rand");
    end
  endtask

  task automatic test_back_to_back;
    mdu_op_t     o;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
    for (int i = 0; i < 6; i++) begin
      rand_op(o, a, b);
      model(o, a, b, eh, el);
      run_op(o, a, b, eh, el, -5, "b2b");
    end
    gap_check("b2b");
  endtask

  task automatic test_reset_mid;
    int nd;
    bus.start = 1'b1;
    bus.op    = MDU_DIVU;
    bus.A     = 32'd1000;
    bus.B     = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op    = MDU_NOP;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_handshake got=b%b_d%b want=b0_d0",
               bus.busy, bus.done);
    end
    checks++;
    if (bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_hilo got=%h_%h want=0_0", bus.HI, bus.LO);
    end
    ref_hi = '0;
    ref_lo = '0;
    nd = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) nd++;
    end
    checks++;
    if (nd != 0) begin
      errors++;
      $display("FAIL rstmid_ghost got=%0d want=0 active cycles", nd);
    end
    run_op(MDU_MULTU, 32'd6, 32'd7,
           32'd0, 32'd42, -5, "post_rst");
    gap_check("post_rst");
  endtask

  initial begin
    test_reset;
    test_mt;
    test_ignored_op;
    test_vectors;
    test_start_while_busy;
    test_random;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
